// File: rtl/dsc_pkg.sv
// Shared types and width helpers for the deterministic stochastic-computing multiplier.
package dsc_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  // Operand bus and product width.
  function automatic int unsigned op_width(input int unsigned n, input int unsigned w);
    return n * w;
  endfunction

  // One extra bit so a full period of 2^(n*w) cycles is representable.
  function automatic int unsigned cyc_width(input int unsigned n, input int unsigned w);
    return n * w + 1;
  endfunction

endpackage

// File: rtl/dsc_nested_ctr.sv
// Chain of per-operand reference counters; stage i steps only when all inner stages are at max.
module dsc_nested_ctr
  import dsc_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned NUM_BITS   = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  logic                                          clr,
  output logic [op_width(NUM_INPUTS, NUM_BITS)-1:0]     ctr,
  output logic [NUM_INPUTS-1:0]                         inner_max,
  output logic                                          last
);

  localparam int unsigned CtrW = op_width(NUM_INPUTS, NUM_BITS);
  localparam logic [NUM_BITS-1:0] One = 1;

  logic [CtrW-1:0] ctr_q;

  // inner_max[i]: stages 0..i-1 all at max, i.e. stage i steps on this cycle.
  always_comb begin
    logic acc;
    acc = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      inner_max[i] = acc;
      acc = acc & (&ctr_q[i*NUM_BITS +: NUM_BITS]);
    end
    last = acc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr_q <= '0;
    end else if (clr) begin
      ctr_q <= '0;
    end else if (en) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (inner_max[i]) begin
          ctr_q[i*NUM_BITS +: NUM_BITS] <= ctr_q[i*NUM_BITS +: NUM_BITS] + One;
        end
      end
    end
  end

  assign ctr = ctr_q;

endmodule

// File: rtl/dsc_mul_nway.sv
// N-way unsigned DSC multiplier: unary streams from nested counters, ANDed and accumulated.
module dsc_mul_nway
  import dsc_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned NUM_BITS   = 8,
  parameter int unsigned EARLY_EXIT = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               start,
  input  logic [NUM_INPUTS*NUM_BITS-1:0]     a,
  output logic [NUM_INPUTS*NUM_BITS-1:0]     z,
  output logic                               busy,
  output logic                               done,
  output logic [NUM_INPUTS*NUM_BITS:0]       cycles
);

  localparam int unsigned OpW    = op_width(NUM_INPUTS, NUM_BITS);
  localparam int unsigned CycW   = cyc_width(NUM_INPUTS, NUM_BITS);
  localparam int unsigned TopLsb = (NUM_INPUTS - 1) * NUM_BITS;
  localparam logic [OpW-1:0]  ZOne = 1;
  localparam logic [CycW-1:0] COne = 1;

  state_t              state_q, state_d;
  logic [OpW-1:0]      op_q, op_d;
  logic [OpW-1:0]      z_q, z_d;
  logic [CycW-1:0]     cycles_q, cycles_d;
  logic [OpW-1:0]      ctr;
  logic [NUM_INPUTS-1:0] inner_max;
  logic                last;
  logic                ctr_clr, ctr_en;
  logic                stream_and, a_has_zero, term;
  logic [NUM_BITS-1:0] top_op_m1;

  dsc_nested_ctr #(
    .NUM_INPUTS (NUM_INPUTS),
    .NUM_BITS   (NUM_BITS)
  ) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .en        (ctr_en),
    .clr       (ctr_clr),
    .ctr       (ctr),
    .inner_max (inner_max),
    .last      (last)
  );

  always_comb begin
    stream_and = 1'b1;
    a_has_zero = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      stream_and = stream_and & (op_q[i*NUM_BITS +: NUM_BITS] > ctr[i*NUM_BITS +: NUM_BITS]);
      a_has_zero = a_has_zero | (a[i*NUM_BITS +: NUM_BITS] == '0);
    end
    // Zero operands never reach RUN in early-exit mode, so this cannot underflow there.
    top_op_m1 = op_q[TopLsb +: NUM_BITS] - 1'b1;
    // inner_max is monotone, so its AND equals the flag of the outermost stage.
    term = (EARLY_EXIT != 0) ? ((&inner_max) && (ctr[TopLsb +: NUM_BITS] == top_op_m1))
                             : last;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    z_d      = z_q;
    cycles_d = cycles_q;
    ctr_clr  = 1'b0;
    ctr_en   = 1'b0;
    case (state_q)
      StRun: begin
        if (en) begin
          ctr_en   = 1'b1;
          cycles_d = cycles_q + COne;
          if (stream_and) z_d = z_q + ZOne;
          if (term) state_d = StDone;
        end
      end
      default: begin
        if (en && start) begin
          op_d     = a;
          z_d      = '0;
          cycles_d = '0;
          ctr_clr  = 1'b1;
          state_d  = ((EARLY_EXIT != 0) && a_has_zero) ? StDone : StRun;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      z_q      <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      z_q      <= z_d;
      cycles_q <= cycles_d;
    end
  end

  assign z      = z_q;
  assign cycles = cycles_q;
  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_dsc_mul_nway.sv
// Scoreboard bench for dsc_mul_nway across four parameter sets.
module tb_dsc_mul_nway;

  typedef struct {
    longint z;
    longint c;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  start_v;
  logic [15:0] a_v [4];

  wire  [3:0]  busy_v, done_v;
  longint      z_v [4];
  longint      cyc_v [4];

  logic [15:0] z_a;  logic [16:0] cyc_a;
  logic [7:0]  z_b;  logic [8:0]  cyc_b;
  logic [11:0] z_c;  logic [12:0] cyc_c;
  logic [11:0] z_d;  logic [12:0] cyc_d;

  exp_t        q [4][$];
  logic [3:0]  done_prev;
  int          nchk;
  int          nerr;

  // A: N=2 W=8 early-exit, B: N=2 W=4 full, C: N=3 W=4 full, D: N=3 W=4 early-exit
  dsc_mul_nway #(.NUM_INPUTS(2), .NUM_BITS(8), .EARLY_EXIT(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .start(start_v[0]), .a(a_v[0]),
    .z(z_a), .busy(busy_v[0]), .done(done_v[0]), .cycles(cyc_a));
  dsc_mul_nway #(.NUM_INPUTS(2), .NUM_BITS(4), .EARLY_EXIT(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .start(start_v[1]), .a(a_v[1][7:0]),
    .z(z_b), .busy(busy_v[1]), .done(done_v[1]), .cycles(cyc_b));
  dsc_mul_nway #(.NUM_INPUTS(3), .NUM_BITS(4), .EARLY_EXIT(0)) u_c (
    .clk(clk), .rst(rst), .en(en), .start(start_v[2]), .a(a_v[2][11:0]),
    .z(z_c), .busy(busy_v[2]), .done(done_v[2]), .cycles(cyc_c));
  dsc_mul_nway #(.NUM_INPUTS(3), .NUM_BITS(4), .EARLY_EXIT(1)) u_d (
    .clk(clk), .rst(rst), .en(en), .start(start_v[3]), .a(a_v[3][11:0]),
    .z(z_d), .busy(busy_v[3]), .done(done_v[3]), .cycles(cyc_d));

  always_comb begin
    z_v[0] = longint'(z_a);  cyc_v[0] = longint'(cyc_a);
    z_v[1] = longint'(z_b);  cyc_v[1] = longint'(cyc_b);
    z_v[2] = longint'(z_c);  cyc_v[2] = longint'(cyc_c);
    z_v[3] = longint'(z_d);  cyc_v[3] = longint'(cyc_d);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: on each rising done, pop the oldest expectation for that instance.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (done_v[k] && !done_prev[k]) begin
        if (q[k].size() == 0) begin
          chk($sformatf("dut%0d_unexpected_done", k), 1, 0);
        end else begin
          e = q[k].pop_front();
          chk($sformatf("dut%0d_z", k), z_v[k], e.z);
          chk($sformatf("dut%0d_cycles", k), cyc_v[k], e.c);
        end
      end
    end
    done_prev <= done_v;
  end

  // Called at a negedge; returns at the negedge where done is seen so the next
  // call can issue start while done is still high.
  task automatic run_op(input int sel, input logic [15:0] av, input longint ez,
                        input longint ec, input longint el, input string name,
                        input int pause_at = -1, input int pause_len = 0,
                        input int abort_at = -1);
    int   lat;
    exp_t e;
    a_v[sel]     = av;
    start_v[sel] = 1'b1;
    e.z = ez;
    e.c = ec;
    q[sel].push_back(e);
    @(negedge clk);
    start_v[sel] = 1'b0;
    lat = 0;
    chk({name, "_busy"}, longint'(busy_v[sel]), (ec != 0) ? 1 : 0);
    while (!done_v[sel] && lat <= el + 4) begin
      if (lat == abort_at) begin
        #2 rst = 1'b0;
        #1;
        chk({name, "_rst_z"}, z_v[sel], 0);
        chk({name, "_rst_cycles"}, cyc_v[sel], 0);
        chk({name, "_rst_busy"}, longint'(busy_v[sel]), 0);
        chk({name, "_rst_done"}, longint'(done_v[sel]), 0);
        void'(q[sel].pop_back());
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk({name, "_idle_busy"}, longint'(busy_v[sel]), 0);
        chk({name, "_idle_done"}, longint'(done_v[sel]), 0);
        return;
      end
      if (pause_len > 0) start_v[sel] = (lat == pause_at + pause_len + 50);
      if (lat == pause_at) begin
        en           = 1'b0;
        start_v[sel] = 1'b1;
        a_v[sel]     = ~av;
        repeat (pause_len) begin
          @(negedge clk);
          lat++;
        end
        en           = 1'b1;
        start_v[sel] = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, el);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] x, y;
    rst     = 1'b1;
    en      = 1'b1;
    start_v = '0;
    for (int k = 0; k < 4; k++) a_v[k] = '0;
    #3 rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dut%0d_reset_z", k), z_v[k], 0);
      chk($sformatf("dut%0d_reset_cycles", k), cyc_v[k], 0);
      chk($sformatf("dut%0d_reset_busy", k), longint'(busy_v[k]), 0);
      chk($sformatf("dut%0d_reset_done", k), longint'(done_v[k]), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // A: operand 1 in bits [15:8], operand 0 in [7:0]
    run_op(0, {8'd0, 8'd200}, 0, 0, 0, "a_zero");
    run_op(0, {8'd3, 8'd200}, 600, 768, 768, "a_200x3");
    run_op(0, {8'd1, 8'd255}, 255, 256, 256, "a_255x1");
    run_op(0, {8'd2, 8'd50}, 100, 512, 612, "a_pause", 200, 100);
    run_op(0, {8'd4, 8'd9}, 36, 1024, 1024, "a_abort", -1, 0, 300);
    run_op(0, {8'd3, 8'd200}, 600, 768, 768, "a_after_rst");
    @(negedge clk);

    // B: full period is always 256
    run_op(1, {8'd0, 4'd15, 4'd15}, 225, 256, 256, "b_15x15");
    run_op(1, {8'd0, 4'd5, 4'd0}, 0, 256, 256, "b_0x5");
    run_op(1, {8'd0, 4'd7, 4'd3}, 21, 256, 256, "b_3x7");
    for (int i = 0; i < 120; i++) begin
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      run_op(1, {8'd0, y, x}, longint'(x) * longint'(y), 256, 256, "b_rand");
    end
    @(negedge clk);

    run_op(2, {4'd0, 4'd15, 4'd15, 4'd15}, 3375, 4096, 4096, "c_15x15x15");
    @(negedge clk);

    run_op(3, {4'd0, 4'd0, 4'd4, 4'd3}, 0, 0, 0, "d_zero");
    run_op(3, {4'd0, 4'd2, 4'd9, 4'd7}, 126, 512, 512, "d_7x9x2");
    run_op(3, {4'd0, 4'd1, 4'd1, 4'd1}, 1, 256, 256, "d_1x1x1");
    run_op(3, {4'd0, 4'd15, 4'd15, 4'd15}, 3375, 3840, 3840, "d_15x15x15");
    repeat (3) @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dut%0d_pending", k), longint'(q[k].size()), 0);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dsc_mul_nway.md
# dsc_mul_nway

Parametrised deterministic stochastic-computing (DSC) multiplier. It computes the exact product of NUM_INPUTS unsigned NUM_BITS-bit operands using unary bit-streams and clock-division nesting. Each operand's reference counter advances only when the next-inner counter wraps, and the ANDed stream bits are accumulated into a binary result. It replaces the fixed 2-input, 8-bit serial multiplier. New behaviour over that block:
- start/busy/done handshake with operand latching;
- optional early-exit mode;
- an exposed cycle count.

## Interface
Parameters:
- NUM_INPUTS, 2, operand count (>=2)
- NUM_BITS, 8, operand width (>=2)
- EARLY_EXIT, 0, 1 = terminate as soon as no further stream 1s are possible

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- en  in  1  global enable; when 0 all state (FSM, counters, accumulators) holds and start is ignored
- start  in  1  request; sampled on an enabled edge in IDLE or DONE
- a  in  NUM_INPUTS*NUM_BITS  operands, operand i = a[i*NUM_BITS +: NUM_BITS]; operand 0 innermost, operand NUM_INPUTS-1 outermost
- z  out  NUM_INPUTS*NUM_BITS  product
- busy  out  1  high in RUN
- done  out  1  high in DONE
- cycles  out  NUM_INPUTS*NUM_BITS+1  number of RUN cycles used by last operation

## Operation
- FSM states: IDLE, RUN, DONE. Reset (rst=0) forces IDLE with z=0, cycles=0, busy=0, done=0, all counters 0, immediately and asynchronously.
- IDLE/DONE + en + start:
  - latch a into an internal operand register;
  - clear z, cycles and all counters.
  - Next state is RUN.
  - Exception: if EARLY_EXIT=1 and any operand == 0, the next state is DONE directly, with z=0 and cycles=0.
- RUN, per enabled cycle:
  - stream bit s_i = (op_i > ctr_i), unsigned compare;
  - if AND of all s_i, then z <= z+1;
  - cycles <= cycles+1;
  - ctr_0 increments every cycle; ctr_i increments when ctr_0..ctr_{i-1} are all at max (2^NUM_BITS-1); wrap to 0.
- Termination in RUN, at the edge that processes the last cycle, next state is DONE:
  - EARLY_EXIT=0: all counters at max (full period, L = 2^(NUM_INPUTS*NUM_BITS) cycles).
  - EARLY_EXIT=1: ctr_{N-1} == op_{N-1}-1 and all inner counters at max, so L = op_{N-1} * 2^((N-1)*NUM_BITS).
- start during RUN is ignored; a changes during RUN have no effect, because operands are latched.
- DONE: z, cycles and done are held until the next accepted start. The next start may be accepted in the same cycle that done is high.
- Width rules:
  - (2^W-1)^N < 2^(N*W), so z never overflows;
  - cycles needs N*W+1 bits to hold 2^(N*W);
  - the result is exact (z == product of operands) in both modes.

## Timing
- Accepted start at edge T0 → busy=1 after T0; the L RUN cycles are processed at edges T1..TL.
- At TL: busy=0, done=1, and z, cycles are final.
- Zero-operand early exit: done=1 after T0, busy never rises.
- en=0 for k cycles during RUN delays done by exactly k cycles; z and cycles are unchanged by the pause.
- rst asserted mid-RUN: outputs drop to reset values asynchronously; start is needed again after release.

## Structure
- Package dsc_pkg:
  - state enum (IDLE, RUN, DONE);
  - localparam helpers for operand, result and cycle widths.
- Sub-module dsc_nested_ctr (params NUM_INPUTS, NUM_BITS):
  - chained counters with clr and en inputs;
  - outputs the flat counter vector, per-stage all-max flags, and a last flag.
- Top holds the FSM, operand register, comparators/AND, z accumulator and cycle counter.

## Test plan
- N=2, W=8, EARLY_EXIT=0, a0=15, a1=15, start → done after 65536 RUN cycles, z=225, cycles=65536.
- N=2, W=8, EARLY_EXIT=1, a0=200, a1=3 → z=600, cycles=768; a0=255, a1=255 → z=65025, cycles=65280.
- EARLY_EXIT=1, a1=0 (or a0=0) → done one cycle after start, busy never high, z=0, cycles=0; with EARLY_EXIT=0 same operands → z=0, cycles=65536.
- N=3, W=4, EARLY_EXIT=0, ops (15,15,15) → z=3375, cycles=4096; EARLY_EXIT=1, ops (7,9,2) → z=126, cycles=512.
- en low for 100 cycles mid-RUN, plus start pulses and a changes during RUN → z and cycles match the unpaused run; done is delayed by exactly 100 cycles.
- rst low mid-RUN → z=0, cycles=0, busy=0, done=0 immediately; new start then gives the correct product; 1000 random operand sets checked against a*b.
